// File: rtl/ej32_pkg.sv
// Shared types, encodings and helpers for the eJ32 byte-wide memory arbiter.
package ej32_pkg;

  localparam int ASZ_DEF = 17;
  localparam int DSZ_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } arb_st_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    LEN_B = 2'b00,
    LEN_S = 2'b01,
    LEN_W = 2'b10
  } ls_len_t;

  // 11 is treated as a word access, same as 10.
  function automatic logic [2:0] len2n(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_B:   n = 3'd1;
      LEN_S:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ej32_mem_arb_if.sv
// Bundle of the fetch, load/store and memory-port signals around ej32_mem_arb.
interface ej32_mem_arb_if #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
);
  logic           if_req;
  logic [ASZ-1:0] if_a;
  logic           if_ack;
  logic [7:0]     if_data;
  logic           ls_req;
  logic           ls_we;
  logic [1:0]     ls_len;
  logic [ASZ-1:0] ls_a;
  logic [DSZ-1:0] ls_wd;
  logic           ls_ack;
  logic [DSZ-1:0] ls_rd;
  logic [ASZ-1:0] mem_a;
  logic           mem_we;
  logic [7:0]     mem_wd;
  logic [7:0]     mem_rd;
  logic           busy;

  modport slave (
    input  if_req, if_a, ls_req, ls_we, ls_len, ls_a, ls_wd, mem_rd,
    output if_ack, if_data, ls_ack, ls_rd, mem_a, mem_we, mem_wd, busy
  );

  modport master (
    output if_req, if_a, ls_req, ls_we, ls_len, ls_a, ls_wd, mem_rd,
    input  if_ack, if_data, ls_ack, ls_rd, mem_a, mem_we, mem_wd, busy
  );
endinterface

// File: rtl/ej32_mem_pack.sv
// Byte shift register, big-endian read assembly with optional sign extension,
// and most-significant-first write byte select for the memory arbiter.
module ej32_mem_pack
  import ej32_pkg::*;
#(
  parameter int DSZ = DSZ_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           shift_en,
  input  logic [2:0]     n,
  input  logic [1:0]     cnt,
  input  logic [DSZ-1:0] wd,
  input  logic [7:0]     mem_rd,
  input  logic           sext,
  output logic [DSZ-1:0] rd_val,
  output logic [7:0]     wd_byte
);

  logic [23:0] shift_r;
  logic [31:0] full_s;
  logic [1:0]  idx_s;

  // Collect earlier read bytes; the final byte comes straight from mem_rd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= 24'd0;
    end else if (clr) begin
      shift_r <= 24'd0;
    end else if (shift_en) begin
      shift_r <= {shift_r[15:0], mem_rd};
    end else begin
      shift_r <= shift_r;
    end
  end

  assign full_s = {shift_r, mem_rd};

  // Right-align to n bytes; stale upper shift bytes are masked off here.
  always_comb begin
    rd_val = full_s;
    case (n)
      3'd1:    rd_val = {{24{sext & full_s[7]}}, full_s[7:0]};
      3'd2:    rd_val = {{16{sext & full_s[15]}}, full_s[15:0]};
      default: rd_val = full_s;
    endcase
  end

  // Byte index n-1-cnt in 2-bit arithmetic: n = 4 wraps to 0, giving 3-cnt.
  assign idx_s = n[1:0] - 2'd1 - cnt;

  // Select the outgoing write byte, most significant first.
  always_comb begin
    wd_byte = 8'd0;
    case (idx_s)
      2'd0:    wd_byte = wd[7:0];
      2'd1:    wd_byte = wd[15:8];
      2'd2:    wd_byte = wd[23:16];
      2'd3:    wd_byte = wd[31:24];
      default: wd_byte = 8'd0;
    endcase
  end

endmodule

// File: rtl/ej32_mem_arb.sv
// eJ32 memory port arbiter/sequencer: alternating IF/LS grant, byte-serial bursts.
// Define EJ32_MEM_SEXT_EN to sign-extend 1- and 2-byte LS reads (default: zero-extend).
module ej32_mem_arb
  import ej32_pkg::*;
#(
  parameter int ASZ = ASZ_DEF,
  parameter int DSZ = DSZ_DEF
) (
  input  logic             clk,
  input  logic             rst,
  ej32_mem_arb_if.slave    bus
);

`ifdef EJ32_MEM_SEXT_EN
  localparam logic SEXT = 1'b1;
`else
  localparam logic SEXT = 1'b0;
`endif

  arb_st_t        state_r;
  owner_t         owner_r;
  logic [ASZ-1:0] base_r;
  logic [1:0]     cnt_r;
  logic [2:0]     n_r;
  logic           we_r;
  logic [DSZ-1:0] wd_r;
  logic           last_ls_r;
  logic [DSZ-1:0] ls_rd_r;
  logic [DSZ-1:0] rd_val_s;
  logic [7:0]     wd_byte_s;
  logic           ls_rd_done_s;

  // Grant, burst sequencing and completion bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      owner_r   <= OWN_IF;
      base_r    <= '0;
      cnt_r     <= 2'd0;
      n_r       <= 3'd1;
      we_r      <= 1'b0;
      wd_r      <= '0;
      last_ls_r <= 1'b0;
      ls_rd_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.ls_req && (!bus.if_req || !last_ls_r)) begin
            owner_r <= OWN_LS;
            base_r  <= bus.ls_a;
            n_r     <= len2n(bus.ls_len);
            we_r    <= bus.ls_we;
            wd_r    <= bus.ls_wd;
            cnt_r   <= 2'd0;
            state_r <= bus.ls_we ? WR : RD;
          end else if (bus.if_req) begin
            owner_r <= OWN_IF;
            base_r  <= bus.if_a;
            n_r     <= 3'd1;
            we_r    <= 1'b0;
            cnt_r   <= 2'd0;
            state_r <= RD;
          end else begin
            state_r <= IDLE;
          end
        end
        RD, WR: begin
          cnt_r <= cnt_r + 2'd1;
          if ({1'b0, cnt_r} == n_r - 3'd1) begin
            state_r <= ACK;
          end else begin
            state_r <= state_r;
          end
        end
        ACK: begin
          if (owner_r == OWN_LS) begin
            last_ls_r <= 1'b1;
            if (!we_r) begin
              ls_rd_r <= rd_val_s;
            end else begin
              ls_rd_r <= ls_rd_r;
            end
          end else begin
            last_ls_r <= 1'b0;
          end
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  ej32_mem_pack #(.DSZ(DSZ)) u_pack (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_r == IDLE),
    .shift_en ((state_r == RD) && (cnt_r != 2'd0)),
    .n        (n_r),
    .cnt      (cnt_r),
    .wd       (wd_r),
    .mem_rd   (bus.mem_rd),
    .sext     (SEXT),
    .rd_val   (rd_val_s),
    .wd_byte  (wd_byte_s)
  );

  assign ls_rd_done_s = (state_r == ACK) && (owner_r == OWN_LS) && !we_r;

  // Outputs decode from state so an async reset clears them without a clock.
  always_comb begin
    bus.busy    = (state_r != IDLE);
    bus.if_ack  = (state_r == ACK) && (owner_r == OWN_IF);
    bus.ls_ack  = (state_r == ACK) && (owner_r == OWN_LS);
    bus.if_data = 8'd0;
    bus.ls_rd   = ls_rd_r;
    bus.mem_a   = '0;
    bus.mem_we  = 1'b0;
    bus.mem_wd  = 8'd0;
    if (bus.if_ack) begin
      bus.if_data = bus.mem_rd;
    end else begin
      bus.if_data = 8'd0;
    end
    if (ls_rd_done_s) begin
      bus.ls_rd = rd_val_s;
    end else begin
      bus.ls_rd = ls_rd_r;
    end
    if ((state_r == RD) || (state_r == WR)) begin
      bus.mem_a = base_r + {{(ASZ-2){1'b0}}, cnt_r};
    end else begin
      bus.mem_a = '0;
    end
    if (state_r == WR) begin
      bus.mem_we = 1'b1;
      bus.mem_wd = wd_byte_s;
    end else begin
      bus.mem_we = 1'b0;
      bus.mem_wd = 8'd0;
    end
  end

endmodule

// File: doc/ej32_mem_arb.md
Name: ej32_mem_arb

Overview:
- Arbiter and sequencer for the single byte-wide memory port.
- Shares the port between two requesters:
  - IF: instruction fetch, feeding the decoder's byte input.
  - LS: the load/store unit, for iaload/saload/baload, the stores, ldi, get and put.
- Breaks LS 1/2/4-byte accesses into sequential big-endian byte cycles and assembles or disassembles the 32-bit value.
- Sits between the fetch/LS units and the memory macro in the eJ32 top.

Parameters:
- ASZ, 17, byte-address width (matches the IU type).
- DSZ, 32, LS data width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_ack
- if_a  in  ASZ  fetch byte address
- if_ack  out  1  one-cycle pulse; if_data valid this cycle
- if_data  out  8  fetched byte
- ls_req  in  1  LS request; held, with all LS inputs stable, until ls_ack
- ls_we  in  1  1 = write, 0 = read
- ls_len  in  2  access size: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = 4 bytes
- ls_a  in  ASZ  base byte address
- ls_wd  in  DSZ  write data; low len bytes used
- ls_ack  out  1  one-cycle completion pulse
- ls_rd  out  DSZ  read data; valid in the ls_ack cycle, held until the next LS grant
- mem_a  out  ASZ  memory byte address
- mem_we  out  1  memory write strobe
- mem_wd  out  8  memory write byte
- mem_rd  in  8  memory read byte; synchronous, valid the cycle after its address
- busy  out  1  state != IDLE

Behaviour:
- States:
  - IDLE: nothing in progress.
  - RD: issuing read addresses.
  - WR: issuing write bytes.
  - ACK: read capture / completion.
- Registers: state, owner (IF/LS), base, cnt[1:0], n (byte count 1/2/4), shift[23:0], last_ls.
- Reset values: state = IDLE, cnt = 0, shift = 0, last_ls = 0, ls_rd = 0.
  - All outputs are decoded from state, so reset forces if_ack = ls_ack = mem_we = busy = 0 and mem_a = 0 immediately.
- Grant, at the IDLE clock edge:
  - Only one request high: grant it.
  - Both high: grant IF if last_ls = 1, else LS.
  - LS completion sets last_ls; IF completion clears it. This alternates IF and LS and prevents starvation.
  - Grant latches base, n (1 for IF), we and wd. cnt is cleared.
  - Next state: WR for an LS write, RD otherwise.
- RD:
  - mem_a = base + cnt, mod 2^ASZ (wraps; no error).
  - cnt increments each cycle.
  - From the second RD cycle on, shift = {shift[15:0], mem_rd}.
  - After n address cycles, go to ACK.
- ACK after a read:
  - Final byte is taken directly from mem_rd.
  - IF owner: if_data = mem_rd.
  - LS owner: ls_rd = {shift, mem_rd}, right-aligned to n bytes and extended per the optional feature; registered on this edge.
  - Pulse the owner's ack; then go to IDLE.
- WR:
  - mem_a = base + cnt; mem_we = 1.
  - mem_wd = byte (n-1-cnt) of wd, most significant first.
  - After n cycles, go to ACK: pulse ls_ack, no memory access, then IDLE.
- Latency from the grant edge, counting in cycles:
  - 1-byte read: ack in cycle 2.
  - 2-byte read: cycle 3. 4-byte read: cycle 5.
  - Writes: ack in cycle n+1.
- Bursts are never interrupted. A request arriving mid-burst waits for IDLE.
- A requester drops its req in the cycle after its ack. IDLE samples req at the following edge.
- Async reset mid-burst aborts immediately:
  - mem_we drops without waiting for the clock.
  - No ack is issued; a partial write remains in memory.
- Outside RD/WR: mem_a = 0, mem_wd = 0, mem_we = 0.

Optional Feature:
- Macro: EJ32_MEM_SEXT_EN.
- Defined: 1- and 2-byte LS reads are sign-extended to DSZ (JVM baload/saload semantics).
- Undefined: they are zero-extended; sign handling is left to the AU.
- IF data and 4-byte reads are unaffected either way.

Decomposition:
- Add to ej32_pkg:
  - arb_st_t enum {IDLE, RD, WR, ACK}.
  - ls_len_t encoding constants LEN_B, LEN_S, LEN_W.
  - Function len2n, mapping ls_len to a byte count.
- Natural sub-module: ej32_mem_pack.
  - Holds the byte shift register, read assembly with extension, and write byte select.
  - Inputs: n, cnt, wd, mem_rd, sext.

Test Plan:
- IF only, if_a = 0x0100, mem[0x100] = 0x10: if_ack pulses in grant+2 with if_data = 0x10; busy high for 2 cycles.
- LS read, len = 10, a = 0x0200, mem = 12 34 56 78: mem_a sequence 200, 201, 202, 203; ls_rd = 0x12345678 at ls_ack in cycle 5.
- LS write, len = 01, a = 0x1FFFF, wd = 0x0000ABCD: writes AB to 1FFFF and CD to 00000 (wrap); mem_we high for 2 cycles; ls_ack in cycle 3.
- LS read, len = 00, byte 0x80, with EJ32_MEM_SEXT_EN: ls_rd = 0xFFFFFF80. Without it: 0x00000080.
- IF and LS requests held high continuously: grants alternate LS, IF, LS, IF; no back-to-back grants to one requester while the other waits.
- rst low during the 3rd cycle of a 4-byte write: mem_we = 0 and busy = 0 immediately; no ls_ack; after release a new IF request completes normally.
